// File: rtl/id_stage_v_if.sv
// id_stage_v_if
//  Fetch <-> decode bundle. Fetch presents a slot (if_valid/if_pc/if_instr);
//  decode answers with is_stall (hold the slot), is_flush (redirect) and
//  branch_target (redirect pc, meaningful only while is_flush is high).
//  master : fetch side
//  slave  : decode side (id_stage_v)
interface id_stage_v_if;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_instr;
   logic        is_stall;
   logic        is_flush;
   logic [31:0] branch_target;

   modport master (
      output if_valid, if_pc, if_instr,
      input  is_stall, is_flush, branch_target
   );

   modport slave (
      input  if_valid, if_pc, if_instr,
      output is_stall, is_flush, branch_target
   );
endinterface

// File: rtl/id_stage_v.sv
// id_stage_v
//  RV32I decode stage. Decodes the fetch slot, reads the 32x32 register file,
//  detects load-use hazards against the ID/EX slot, resolves JAL early
//  (redirects fetch and squashes FLUSH_SHADOW following slots) and registers
//  the ID/EX bundle.
//  Optional feature macro: ID_WB_BYPASS_EN -- when defined, a register read of
//  the register being written back in the same cycle returns wb_data.
// Ports
//  clk, reset          clock, synchronous active-high reset
//  fetch               fetch bundle (slave side of id_stage_v_if)
//  wb_we/wb_rd/wb_data register file write port
//  ex_*                registered ID/EX bundle
module id_stage_v #(
   parameter int FLUSH_SHADOW = 2
) (
   input  logic         clk,
   input  logic         reset,
   id_stage_v_if.slave  fetch,
   input  logic         wb_we,
   input  logic [4:0]   wb_rd,
   input  logic [31:0]  wb_data,
   output logic         ex_valid,
   output logic [31:0]  ex_pc,
   output logic [3:0]   ex_op,
   output logic [2:0]   ex_funct3,
   output logic         ex_funct7b5,
   output logic [4:0]   ex_rs1,
   output logic [4:0]   ex_rs2,
   output logic [4:0]   ex_rd,
   output logic [31:0]  ex_rs1_data,
   output logic [31:0]  ex_rs2_data,
   output logic [31:0]  ex_imm,
   output logic         ex_reg_write,
   output logic         ex_mem_read,
   output logic         ex_mem_write
);

   localparam logic [3:0] OP_NOP   = 4'd0;
   localparam logic [3:0] OP_ALU_R = 4'd1;
   localparam logic [3:0] OP_ALU_I = 4'd2;
   localparam logic [3:0] OP_LOAD  = 4'd3;
   localparam logic [3:0] OP_STORE = 4'd4;
   localparam logic [3:0] OP_BR    = 4'd5;
   localparam logic [3:0] OP_JAL   = 4'd6;
   localparam logic [3:0] OP_JALR  = 4'd7;
   localparam logic [3:0] OP_LUI   = 4'd8;
   localparam logic [3:0] OP_AUIPC = 4'd9;

   logic [31:0] rf [32];
   logic [1:0]  shadow;

   logic [31:0] instr;
   logic        live;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

   logic [3:0]  dec_op;
   logic [4:0]  dec_rs1, dec_rs2, dec_rd;
   logic [31:0] dec_imm;
   logic        dec_wr, dec_mr, dec_mw;
   logic [31:0] rs1_data, rs2_data;
   logic        stall, flush;

   assign instr = fetch.if_instr;
   assign live  = fetch.if_valid & (shadow == 2'd0);

   assign imm_i = {{20{instr[31]}}, instr[31:20]};
   assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   assign imm_u = {instr[31:12], 12'h000};
   assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

   always_comb begin
      logic use1, use2, wr;
      use1    = 1'b0;
      use2    = 1'b0;
      wr      = 1'b0;
      dec_op  = OP_NOP;
      dec_imm = 32'h0;
      dec_mr  = 1'b0;
      dec_mw  = 1'b0;
      if (live) begin
         unique case (instr[6:0])
            7'b0110011: begin dec_op = OP_ALU_R; use1 = 1'b1; use2 = 1'b1; wr = 1'b1; end
            7'b0010011: begin dec_op = OP_ALU_I; use1 = 1'b1; wr = 1'b1; dec_imm = imm_i; end
            7'b0000011: begin dec_op = OP_LOAD;  use1 = 1'b1; wr = 1'b1; dec_imm = imm_i; dec_mr = 1'b1; end
            7'b0100011: begin dec_op = OP_STORE; use1 = 1'b1; use2 = 1'b1; dec_imm = imm_s; dec_mw = 1'b1; end
            7'b1100011: begin dec_op = OP_BR;    use1 = 1'b1; use2 = 1'b1; dec_imm = imm_b; end
            7'b1101111: begin dec_op = OP_JAL;   wr = 1'b1; dec_imm = imm_j; end
            7'b1100111: begin dec_op = OP_JALR;  use1 = 1'b1; wr = 1'b1; dec_imm = imm_i; end
            7'b0110111: begin dec_op = OP_LUI;   wr = 1'b1; dec_imm = imm_u; end
            7'b0010111: begin dec_op = OP_AUIPC; wr = 1'b1; dec_imm = imm_u; end
            default:    dec_op = OP_NOP;
         endcase
      end
      dec_rs1 = use1 ? instr[19:15] : 5'd0;
      dec_rs2 = use2 ? instr[24:20] : 5'd0;
      dec_wr  = wr & (instr[11:7] != 5'd0);
      dec_rd  = dec_wr ? instr[11:7] : 5'd0;
   end

   always_comb begin
      rs1_data = (dec_rs1 == 5'd0) ? 32'h0 : rf[dec_rs1];
      rs2_data = (dec_rs2 == 5'd0) ? 32'h0 : rf[dec_rs2];
`ifdef ID_WB_BYPASS_EN
      if (wb_we && (wb_rd == dec_rs1) && (dec_rs1 != 5'd0)) rs1_data = wb_data;
      if (wb_we && (wb_rd == dec_rs2) && (dec_rs2 != 5'd0)) rs2_data = wb_data;
`endif
   end

   // Unused source indices are already zeroed, and ex_rd!=0 is required, so a
   // zero index can never produce a false hazard.
   assign stall = ~reset & live & ex_valid & ex_mem_read & (ex_rd != 5'd0) &
                  ((ex_rd == dec_rs1) | (ex_rd == dec_rs2));
   assign flush = ~reset & live & ~stall & (dec_op == OP_JAL);

   assign fetch.is_stall      = stall;
   assign fetch.is_flush      = flush;
   assign fetch.branch_target = fetch.if_pc + imm_j;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) rf[i] <= 32'h0;
      end else if (wb_we && (wb_rd != 5'd0)) begin
         rf[wb_rd] <= wb_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset)                              shadow <= 2'd0;
      else if (flush)                         shadow <= 2'(FLUSH_SHADOW);
      else if (!stall && (shadow != 2'd0))    shadow <= shadow - 2'd1;
   end

   // A stall or a dead slot both load an all-zero bubble.
   always_ff @(posedge clk) begin
      if (reset || stall || !live) begin
         ex_valid     <= 1'b0;
         ex_pc        <= 32'h0;
         ex_op        <= OP_NOP;
         ex_funct3    <= 3'd0;
         ex_funct7b5  <= 1'b0;
         ex_rs1       <= 5'd0;
         ex_rs2       <= 5'd0;
         ex_rd        <= 5'd0;
         ex_rs1_data  <= 32'h0;
         ex_rs2_data  <= 32'h0;
         ex_imm       <= 32'h0;
         ex_reg_write <= 1'b0;
         ex_mem_read  <= 1'b0;
         ex_mem_write <= 1'b0;
      end else begin
         ex_valid     <= 1'b1;
         ex_pc        <= fetch.if_pc;
         ex_op        <= dec_op;
         ex_funct3    <= instr[14:12];
         ex_funct7b5  <= instr[30];
         ex_rs1       <= dec_rs1;
         ex_rs2       <= dec_rs2;
         ex_rd        <= dec_rd;
         ex_rs1_data  <= rs1_data;
         ex_rs2_data  <= rs2_data;
         ex_imm       <= dec_imm;
         ex_reg_write <= dec_wr;
         ex_mem_read  <= dec_mr;
         ex_mem_write <= dec_mw;
      end
   end

endmodule

// File: tb/tb_id_stage_v.sv
module tb_id_stage_v;

   typedef struct {
      logic        v;
      logic [31:0] pc;
      logic [3:0]  op;
      logic [4:0]  rs1, rs2, rd;
      logic [31:0] imm, d1, d2;
      logic        rw, mr, mw;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        wb_we;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        ex_valid, ex_funct7b5, ex_reg_write, ex_mem_read, ex_mem_write;
   logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
   logic [3:0]  ex_op;
   logic [2:0]  ex_funct3;
   logic [4:0]  ex_rs1, ex_rs2, ex_rd;

   int total = 0;
   int bad   = 0;
   exp_t exq[$];

   id_stage_v_if fif ();

   id_stage_v #(.FLUSH_SHADOW(2)) dut (
      .clk(clk), .reset(reset), .fetch(fif.slave),
      .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
      .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_op(ex_op), .ex_funct3(ex_funct3),
      .ex_funct7b5(ex_funct7b5), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
      .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
      .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic exp_t mk(input logic v, input logic [31:0] pc, input logic [3:0] op,
                               input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                               input logic [31:0] imm, input logic [31:0] d1, input logic [31:0] d2,
                               input logic rw, input logic mr, input logic mw);
      exp_t e;
      e.v = v; e.pc = pc; e.op = op; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd;
      e.imm = imm; e.d1 = d1; e.d2 = d2; e.rw = rw; e.mr = mr; e.mw = mw;
      return e;
   endfunction

   function automatic exp_t bub();
      return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endfunction

   task automatic compare_ex(input string tag);
      exp_t e;
      e = exq.pop_front();
      check({tag, ".valid"}, 32'(ex_valid), 32'(e.v));
      check({tag, ".pc"},    ex_pc, e.pc);
      check({tag, ".op"},    32'(ex_op), 32'(e.op));
      check({tag, ".rs1"},   32'(ex_rs1), 32'(e.rs1));
      check({tag, ".rs2"},   32'(ex_rs2), 32'(e.rs2));
      check({tag, ".rd"},    32'(ex_rd), 32'(e.rd));
      check({tag, ".imm"},   ex_imm, e.imm);
      check({tag, ".d1"},    ex_rs1_data, e.d1);
      check({tag, ".d2"},    ex_rs2_data, e.d2);
      check({tag, ".rw"},    32'(ex_reg_write), 32'(e.rw));
      check({tag, ".mr"},    32'(ex_mem_read), 32'(e.mr));
      check({tag, ".mw"},    32'(ex_mem_write), 32'(e.mw));
   endtask

   // One fetch slot: drive, check combinational controls, push expectation,
   // then compare the ID/EX bundle one cycle later.
   task automatic issue(input string tag, input logic v, input logic [31:0] pc,
                        input logic [31:0] instr, input exp_t e,
                        input logic xs, input logic xf, input logic [31:0] xt);
      @(negedge clk);
      fif.if_valid = v;
      fif.if_pc    = pc;
      fif.if_instr = instr;
      #1;
      check({tag, ".stall"}, 32'(fif.is_stall), 32'(xs));
      check({tag, ".flush"}, 32'(fif.is_flush), 32'(xf));
      if (xf) check({tag, ".target"}, fif.branch_target, xt);
      exq.push_back(e);
      @(posedge clk);
      #1;
      wb_we = 1'b0;
      compare_ex(tag);
   endtask

   task automatic set_wb(input logic [4:0] rd, input logic [31:0] d);
      wb_we = 1'b1; wb_rd = rd; wb_data = d;
   endtask

   localparam logic [31:0] ADDI_X1   = 32'h0050_0093;
   localparam logic [31:0] LW_X2     = 32'h0000_A103;
   localparam logic [31:0] ADD_X3    = 32'h0011_01B3;
   localparam logic [31:0] JAL_X1    = 32'h0200_00EF;
   localparam logic [31:0] ADDI_X4   = 32'h0070_0213;
   localparam logic [31:0] ADD_X5    = 32'h0000_02B3;
   localparam logic [31:0] ADDI_X6   = 32'h0012_8313;
   localparam logic [31:0] SW_X1     = 32'h0011_2423;
   localparam logic [31:0] BEQ_M4    = 32'hFE20_8EE3;
   localparam logic [31:0] LUI_X7    = 32'h1234_53B7;
   localparam logic [31:0] CUSTOM0   = 32'h0000_000B;
`ifdef ID_WB_BYPASS_EN
   localparam logic [31:0] BYP_X5 = 32'h0000_1234;
`else
   localparam logic [31:0] BYP_X5 = 32'h0000_0000;
`endif

   initial begin
      reset = 1'b1; wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'h0;
      fif.if_valid = 1'b0; fif.if_pc = 32'h0; fif.if_instr = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      check("rst.ex_valid", 32'(ex_valid), 0);
      check("rst.ex_rd", 32'(ex_rd), 0);
      check("rst.ex_imm", ex_imm, 0);
      check("rst.stall", 32'(fif.is_stall), 0);
      check("rst.flush", 32'(fif.is_flush), 0);
      @(negedge clk);
      reset = 1'b0;

      // Test 1 (with x1=5 written through a dead slot first)
      set_wb(5'd1, 32'd5);
      issue("dead_wb", 0, 32'h0, ADDI_X1, bub(), 0, 0, 0);
      issue("addi", 1, 32'h0, ADDI_X1, mk(1, 32'h0, 2, 0, 0, 1, 5, 0, 0, 1, 0, 0), 0, 0, 0);

      // Test 2: load-use stall, x2 written during the stall cycle
      issue("lw", 1, 32'h4, LW_X2, mk(1, 32'h4, 3, 1, 0, 2, 0, 5, 0, 1, 1, 0), 0, 0, 0);
      set_wb(5'd2, 32'h77);
      issue("add_stall", 1, 32'h8, ADD_X3, bub(), 1, 0, 0);
      issue("add", 1, 32'h8, ADD_X3, mk(1, 32'h8, 1, 2, 1, 3, 0, 32'h77, 5, 1, 0, 0), 0, 0, 0);

      // Test 3: JAL redirect and two squashed slots, the second holding a JAL
      issue("jal", 1, 32'h10, JAL_X1, mk(1, 32'h10, 6, 0, 0, 1, 32'h20, 0, 0, 1, 0, 0), 0, 1, 32'h30);
      issue("sq1", 1, 32'h14, ADDI_X4, bub(), 0, 0, 0);
      issue("sq2", 1, 32'h18, JAL_X1, bub(), 0, 0, 0);
      issue("after_jal", 1, 32'h30, ADDI_X4, mk(1, 32'h30, 2, 0, 0, 4, 7, 0, 0, 1, 0, 0), 0, 0, 0);

      // Test 4: write to x0 ignored
      set_wb(5'd0, 32'hDEAD);
      issue("wb_x0", 0, 32'h0, 32'h0, bub(), 0, 0, 0);
      issue("rd_x0", 1, 32'h34, ADD_X5, mk(1, 32'h34, 1, 0, 0, 5, 0, 0, 0, 1, 0, 0), 0, 0, 0);

      // Test 5: same-cycle writeback visibility
      set_wb(5'd5, 32'h1234);
      issue("byp", 1, 32'h38, ADDI_X6, mk(1, 32'h38, 2, 5, 0, 6, 1, BYP_X5, 0, 1, 0, 0), 0, 0, 0);
      issue("byp_next", 1, 32'h3C, ADDI_X6, mk(1, 32'h3C, 2, 5, 0, 6, 1, 32'h1234, 0, 1, 0, 0), 0, 0, 0);

      // Other classes
      issue("sw", 1, 32'h40, SW_X1, mk(1, 32'h40, 4, 2, 1, 0, 8, 32'h77, 5, 0, 0, 1), 0, 0, 0);
      issue("beq", 1, 32'h44, BEQ_M4, mk(1, 32'h44, 5, 1, 2, 0, 32'hFFFF_FFFC, 5, 32'h77, 0, 0, 0), 0, 0, 0);
      check("beq.f7b5", 32'(ex_funct7b5), 1);
      issue("lui", 1, 32'h48, LUI_X7, mk(1, 32'h48, 8, 0, 0, 7, 32'h1234_5000, 0, 0, 1, 0, 0), 0, 0, 0);
      issue("unk", 1, 32'h4C, CUSTOM0, mk(1, 32'h4C, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0, 0);

      // Test 6a: reset during a stall
      issue("lw2", 1, 32'h50, LW_X2, mk(1, 32'h50, 3, 1, 0, 2, 0, 5, 0, 1, 1, 0), 0, 0, 0);
      check("lw2.f3", 32'(ex_funct3), 2);
      @(negedge clk);
      fif.if_valid = 1'b1; fif.if_pc = 32'h54; fif.if_instr = ADD_X3;
      #1;
      check("rst_stall.pre", 32'(fif.is_stall), 1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("rst_stall.valid", 32'(ex_valid), 0);
      check("rst_stall.mr", 32'(ex_mem_read), 0);
      check("rst_stall.rd", 32'(ex_rd), 0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("rst_stall.post", 32'(fif.is_stall), 0);
      // RF must have been cleared
      issue("rf_clr", 1, 32'h58, SW_X1, mk(1, 32'h58, 4, 2, 1, 0, 8, 0, 0, 0, 0, 1), 0, 0, 0);

      // Test 6b: reset during JAL shadow
      issue("jal2", 1, 32'h5C, JAL_X1, mk(1, 32'h5C, 6, 0, 0, 1, 32'h20, 0, 0, 1, 0, 0), 0, 1, 32'h7C);
      @(negedge clk);
      reset = 1'b1; fif.if_valid = 1'b0;
      @(posedge clk);
      #1;
      check("rst_sh.valid", 32'(ex_valid), 0);
      check("rst_sh.pc", ex_pc, 0);
      @(negedge clk);
      reset = 1'b0;
      issue("post_sh", 1, 32'h7C, ADDI_X4, mk(1, 32'h7C, 2, 0, 0, 4, 7, 0, 0, 1, 0, 0), 0, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
